// File: rtl/morse_symbol_decoder.sv
// Morse character decoder: packs dot/dash symbols into a 2-bit-per-element code and, at each gap,
// emits ASCII plus a 7-segment glyph through a one-entry valid/ready output register.
module morse_symbol_decoder #(
  parameter int MAX_LEN        = 5,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [1:0] sym_type,
  output logic       sym_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_ascii,
  output logic [6:0] out_seg,
  output logic       out_err,
  output logic [6:0] seg_disp
);

  localparam int               CW          = 2 * MAX_LEN;
  localparam int               CNT_W       = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_LEN);
  localparam logic [6:0]       SEG_BLANK   = 7'h7F;
  localparam logic [7:0]       ASCII_SPACE = 8'h20;
  localparam logic [7:0]       ASCII_ERR   = 8'h3F;
  localparam logic [1:0]       SYM_WORD    = 2'b00;
  localparam logic [1:0]       SYM_DOT     = 2'b01;
  localparam logic [1:0]       SYM_DASH    = 2'b10;
  localparam logic [1:0]       SYM_CHAR    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PEND_SPACE} state_e;

  typedef struct packed {
    logic       hit;
    logic [7:0] ascii;
    logic [6:0] seg;
  } glyph_t;

  // Codes are right-aligned with nonzero elements, so the value alone identifies the length.
  function automatic glyph_t lookup(input logic [CW-1:0] code);
    logic [15:0] wide;
    glyph_t      g;
    wide = 16'(code);
    g    = '{hit: 1'b1, ascii: ASCII_ERR, seg: SEG_BLANK};
    case (wide)
      16'b01_10:          {g.ascii, g.seg} = {"A", 7'b0001000};
      16'b10_01_01_01:    {g.ascii, g.seg} = {"B", 7'b1100000};
      16'b10_01_10_01:    {g.ascii, g.seg} = {"C", 7'b0110001};
      16'b10_01_01:       {g.ascii, g.seg} = {"D", 7'b1000010};
      16'b01:             {g.ascii, g.seg} = {"E", 7'b0110000};
      16'b01_01_10_01:    {g.ascii, g.seg} = {"F", 7'b0111000};
      16'b10_10_01:       {g.ascii, g.seg} = {"G", 7'b0100001};
      16'b01_01_01_01:    {g.ascii, g.seg} = {"H", 7'b1001000};
      16'b01_01:          {g.ascii, g.seg} = {"I", 7'b1111001};
      16'b01_10_10_10:    {g.ascii, g.seg} = {"J", 7'b1000011};
      16'b10_01_10:       {g.ascii, g.seg} = {"K", SEG_BLANK};
      16'b01_10_01_01:    {g.ascii, g.seg} = {"L", 7'b1110001};
      16'b10_10:          {g.ascii, g.seg} = {"M", SEG_BLANK};
      16'b10_01:          {g.ascii, g.seg} = {"N", 7'b1101010};
      16'b10_10_10:       {g.ascii, g.seg} = {"O", 7'b1100010};
      16'b01_10_10_01:    {g.ascii, g.seg} = {"P", 7'b0011000};
      16'b10_10_01_10:    {g.ascii, g.seg} = {"Q", 7'b0001100};
      16'b01_10_01:       {g.ascii, g.seg} = {"R", 7'b1111010};
      16'b01_01_01:       {g.ascii, g.seg} = {"S", 7'b0100100};
      16'b10:             {g.ascii, g.seg} = {"T", 7'b1110000};
      16'b01_01_10:       {g.ascii, g.seg} = {"U", 7'b1000001};
      16'b01_01_01_10:    {g.ascii, g.seg} = {"V", SEG_BLANK};
      16'b01_10_10:       {g.ascii, g.seg} = {"W", SEG_BLANK};
      16'b10_01_01_10:    {g.ascii, g.seg} = {"X", SEG_BLANK};
      16'b10_01_10_10:    {g.ascii, g.seg} = {"Y", 7'b1000100};
      16'b10_10_01_01:    {g.ascii, g.seg} = {"Z", 7'b0010010};
      16'b10_10_10_10_10: {g.ascii, g.seg} = {"0", 7'b0000001};
      16'b01_10_10_10_10: {g.ascii, g.seg} = {"1", 7'b1001111};
      16'b01_01_10_10_10: {g.ascii, g.seg} = {"2", 7'b0010010};
      16'b01_01_01_10_10: {g.ascii, g.seg} = {"3", 7'b0000110};
      16'b01_01_01_01_10: {g.ascii, g.seg} = {"4", 7'b1001100};
      16'b01_01_01_01_01: {g.ascii, g.seg} = {"5", 7'b0100100};
      16'b10_01_01_01_01: {g.ascii, g.seg} = {"6", 7'b0100000};
      16'b10_10_01_01_01: {g.ascii, g.seg} = {"7", 7'b0001111};
      16'b10_10_10_01_01: {g.ascii, g.seg} = {"8", 7'b0000000};
      16'b10_10_10_10_01: {g.ascii, g.seg} = {"9", 7'b0000100};
      default:            g.hit = 1'b0;
    endcase
    return g;
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_err_q;
  logic [7:0]       out_ascii_q;
  logic [6:0]       out_seg_q, seg_disp_q;

  logic       is_elem, acc_empty, slot_free, take, load;
  logic [7:0] ld_ascii;
  logic [6:0] ld_seg;
  logic       ld_err;
  glyph_t     glyph;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    is_elem   = (sym_type == SYM_DOT) || (sym_type == SYM_DASH);
    acc_empty = (cnt_q == '0) && !ovf_q;
    slot_free = !out_valid_q || out_ready;
    sym_ready = 1'b0;
    if (!rst && state_q != S_PEND_SPACE) begin
      if (is_elem)                                  sym_ready = 1'b1;
      else if (sym_type == SYM_CHAR && acc_empty)   sym_ready = 1'b1;
      else                                          sym_ready = slot_free;
    end
    take = sym_valid && sym_ready;
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    load     = 1'b0;
    ld_ascii = ASCII_SPACE;
    ld_seg   = SEG_BLANK;
    ld_err   = 1'b0;
    glyph    = lookup(code_q);

    if (take && is_elem) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        code_d = {code_q[CW-3:0], sym_type};
        cnt_d  = cnt_q + CNT_W'(1);
      end
      state_d = S_COLLECT;
    end else if (take && !acc_empty) begin
      load = 1'b1;
      if (glyph.hit && !ovf_q) begin
        ld_ascii = glyph.ascii;
        ld_seg   = glyph.seg;
      end else begin
        ld_ascii = ASCII_ERR;
        ld_err   = 1'b1;
      end
      code_d  = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = (sym_type == SYM_WORD) ? S_PEND_SPACE : S_IDLE;
    end else if (take && sym_type == SYM_WORD) begin
      load = 1'b1;
    end else if (state_q == S_PEND_SPACE && slot_free) begin
      load    = 1'b1;
      state_d = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ascii_q <= 8'h00;
      out_seg_q   <= SEG_BLANK;
      out_err_q   <= 1'b0;
      seg_disp_q  <= SEG_BLANK;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_ascii_q <= ld_ascii;
      out_seg_q   <= ld_seg;
      out_err_q   <= ld_err;
      if (!ld_err) seg_disp_q <= ld_seg;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Glyphs are held active-low internally; the other polarity is a plain inversion.
  assign out_valid = out_valid_q;
  assign out_ascii = out_ascii_q;
  assign out_err   = out_err_q;
  assign out_seg   = out_seg_q ^ {7{~SEG_ACTIVE_LOW}};
  assign seg_disp  = seg_disp_q ^ {7{~SEG_ACTIVE_LOW}};

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Bench for morse_symbol_decoder: directed scenarios then randomized traffic, every cycle
// compared against a string/table-based reference model of the symbol stream.
module tb_morse_symbol_decoder;

  localparam int         MAX_LEN = 5;
  localparam logic [1:0] T_WORD  = 2'b00;
  localparam logic [1:0] T_DOT   = 2'b01;
  localparam logic [1:0] T_DASH  = 2'b10;
  localparam logic [1:0] T_CHAR  = 2'b11;
  localparam logic [6:0] BLANK   = 7'h7F;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       sym_valid = 1'b0;
  logic [1:0] sym_type  = 2'b00;
  logic       out_ready = 1'b0;
  logic       sym_ready, out_valid, out_err;
  logic [7:0] out_ascii;
  logic [6:0] out_seg, seg_disp;

  always #5 clk = ~clk;

  morse_symbol_decoder #(.MAX_LEN(MAX_LEN), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .sym_valid (sym_valid),
    .sym_type  (sym_type),
    .sym_ready (sym_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ascii (out_ascii),
    .out_seg   (out_seg),
    .out_err   (out_err),
    .seg_disp  (seg_disp)
  );

  // Alphabet A..Z then 0..9; ASCII is derived from the index.
  string morse_tab [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."};

  logic [6:0] glyph_tab [36] = '{
    7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000, 7'b0100001,
    7'b1001000, 7'b1111001, 7'b1000011, 7'b1111111, 7'b1110001, 7'b1111111, 7'b1101010,
    7'b1100010, 7'b0011000, 7'b0001100, 7'b1111010, 7'b0100100, 7'b1110000, 7'b1000001,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1000100, 7'b0010010,
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000,
    7'b0001111, 7'b0000000, 7'b0000100};

  int n_vec  = 0;
  int n_miss = 0;

  string      m_elems;
  bit         m_ovf, m_pend, m_full, m_err;
  logic [7:0] m_ascii;
  logic [6:0] m_seg, m_disp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic m_reset();
    m_elems = "";
    m_ovf   = 1'b0;
    m_pend  = 1'b0;
    m_full  = 1'b0;
    m_ascii = 8'h00;
    m_seg   = BLANK;
    m_err   = 1'b0;
    m_disp  = BLANK;
  endtask

  task automatic m_load(input logic [7:0] a, input logic [6:0] s, input bit e);
    m_ascii = a;
    m_seg   = s;
    m_err   = e;
    if (!e) m_disp = s;
  endtask

  task automatic m_emit_char();
    int idx;
    idx = -1;
    if (!m_ovf)
      for (int i = 0; i < 36; i++)
        if (morse_tab[i] == m_elems) idx = i;
    if (idx < 0) m_load(8'h3F, BLANK, 1'b1);
    else         m_load(8'((idx < 26) ? (65 + idx) : (48 + idx - 26)), glyph_tab[idx], 1'b0);
  endtask

  function automatic bit model_ready(input logic [1:0] t, input bit r, input bit rs);
    if (rs || m_pend)                                     return 1'b0;
    if (t == T_DOT || t == T_DASH)                        return 1'b1;
    if (t == T_CHAR && m_elems.len() == 0 && !m_ovf)      return 1'b1;
    return !m_full || r;
  endfunction

  // One clock: drive at negedge, check sym_ready, advance the model at posedge, check outputs after.
  task automatic cycle(input bit v, input logic [1:0] t, input bit r, input bit rs, output bit took);
    bit exp_rdy, loaded;
    sym_valid = v;
    sym_type  = t;
    out_ready = r;
    rst       = rs;
    #1;
    exp_rdy = model_ready(t, r, rs);
    check("sym_ready", sym_ready, exp_rdy);
    took = v && exp_rdy;
    @(posedge clk);
    if (rs) begin
      m_reset();
    end else begin
      loaded = 1'b0;
      if (took && (t == T_DOT || t == T_DASH)) begin
        if (m_elems.len() == MAX_LEN) m_ovf = 1'b1;
        else m_elems = {m_elems, (t == T_DOT) ? "." : "-"};
      end else if (took && (m_elems.len() != 0 || m_ovf)) begin
        m_emit_char();
        loaded  = 1'b1;
        m_elems = "";
        m_ovf   = 1'b0;
        if (t == T_WORD) m_pend = 1'b1;
      end else if (took && t == T_WORD) begin
        m_load(8'h20, BLANK, 1'b0);
        loaded = 1'b1;
      end else if (m_pend && (!m_full || r)) begin
        m_load(8'h20, BLANK, 1'b0);
        loaded = 1'b1;
        m_pend = 1'b0;
      end
      if (loaded) m_full = 1'b1;
      else if (r) m_full = 1'b0;
    end
    #1;
    check("out_valid", out_valid, m_full);
    check("out_ascii", out_ascii, m_ascii);
    check("out_seg",   out_seg,   m_seg);
    check("out_err",   out_err,   m_err);
    check("seg_disp",  seg_disp,  m_disp);
    @(negedge clk);
  endtask

  task automatic step(input bit v, input logic [1:0] t, input bit r);
    bit took;
    cycle(v, t, r, 1'b0, took);
  endtask

  task automatic send(input logic [1:0] t, input bit r);
    bit took;
    took = 1'b0;
    for (int n = 0; n < 20 && !took; n++) cycle(1'b1, t, r, 1'b0, took);
    check("send_accepted", took, 1'b1);
  endtask

  task automatic do_reset(input int n);
    bit took;
    for (int i = 0; i < n; i++) cycle(1'b0, T_DOT, 1'b0, 1'b1, took);
  endtask

  initial begin
    bit         v, r, rs, took;
    logic [1:0] t;
    int         k;
    m_reset();
    @(negedge clk);
    do_reset(2);
    step(1'b0, T_DOT, 1'b1);

    // A, then the output register drains after one cycle
    send(T_DOT, 1'b1); send(T_DASH, 1'b1); send(T_CHAR, 1'b1);
    step(1'b0, T_DOT, 1'b1); step(1'b0, T_DOT, 1'b1);

    // 0 then 1 back to back
    for (int i = 0; i < 5; i++) send(T_DASH, 1'b1);
    send(T_CHAR, 1'b1);
    send(T_DOT, 1'b1);
    for (int i = 0; i < 4; i++) send(T_DASH, 1'b1);
    send(T_CHAR, 1'b1);
    step(1'b0, T_DOT, 1'b1);

    // overflow, then a normal character
    for (int i = 0; i < 6; i++) send(T_DOT, 1'b1);
    send(T_CHAR, 1'b1);
    send(T_DOT, 1'b1); send(T_CHAR, 1'b1);
    step(1'b0, T_DOT, 1'b1);

    // stalled consumer: char_end blocked, dots still accepted, then pop and push together
    send(T_DOT, 1'b0); send(T_CHAR, 1'b0);
    step(1'b1, T_DOT, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, T_CHAR, 1'b0);
    send(T_CHAR, 1'b1);
    step(1'b0, T_DOT, 1'b1);

    // S followed by a word gap
    for (int i = 0; i < 3; i++) send(T_DOT, 1'b1);
    send(T_WORD, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, T_DOT, 1'b1);

    // empty word gap, then reset mid-character
    send(T_WORD, 1'b1);
    send(T_DASH, 1'b1); send(T_DASH, 1'b1);
    do_reset(1);
    send(T_DOT, 1'b1); send(T_CHAR, 1'b1);
    step(1'b0, T_DOT, 1'b1); step(1'b0, T_DOT, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 499) == 0);
      k  = $urandom_range(0, 9);
      t  = (k < 4) ? T_DOT : (k < 7) ? T_DASH : (k < 9) ? T_CHAR : T_WORD;
      cycle(v, t, r, rs, took);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
